tdc_popcount_pipe: RTL and testbench

TDC_POPCOUNT_PIPE -- requirements
Module: tdc_popcount_pipe

---
 rtl/tdc_popcount_pipe.sv | 143 ++++++++++++++
 tb/tb_tdc_popcount_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_popcount_pipe.sv
// tdc_popcount_pipe: pipelined ones-counter for a TDC thermometer word.
// Stage 0 captures the raw sample, stage 1 counts ones per 6-bit chunk,
// then a registered binary adder tree reduces the chunk counts to one total.
// Optional macro TDC_POPCOUNT_BUBBLE_FILTER_EN adds a 3-bit majority
// bubble filter stage between stage 0 and the chunk counters.
module tdc_popcount_pipe #(
  parameter int WIDTH = 192,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  output logic [OUT_W-1:0] oCount,
  output logic             oZero,
  output logic             oFull
);

  localparam int NCHUNK = WIDTH / 6;
  localparam int LEVELS = $clog2(NCHUNK);
  localparam int NPAD   = 1 << LEVELS;
`ifdef TDC_POPCOUNT_BUBBLE_FILTER_EN
  localparam int FILT   = 1;
`else
  localparam int FILT   = 0;
`endif
  // Valid chain index k marks the stage whose register holds the sample
  // that arrived k+1 cycles ago; the last entry is oValid.
  localparam int LAT    = 2 + FILT + LEVELS;

  logic [WIDTH-1:0] data_q;
  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] cnt_src;
  logic [2:0]       chunk_d [NPAD];
  logic [OUT_W-1:0] cnt_d;
  logic [OUT_W-1:0] cnt_q;
  logic             zero_q;
  logic             full_q;

  // Stage 0: capture the raw sample every cycle, valid or not.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) data_q <= '0;
    else         data_q <= iData;
  end

  // Valid bits march alongside the data, one per pipeline register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) vld_q <= '0;
    else         vld_q <= {vld_q[LAT-2:0], iValid};
  end

`ifdef TDC_POPCOUNT_BUBBLE_FILTER_EN
  logic [WIDTH+1:0] ext;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] filt_q;

  // Below bit 0 the chain is treated as filled, above the top as empty.
  assign ext = {1'b0, data_q, 1'b1};

  // Each bit becomes the majority of itself and its two neighbours.
  always_comb begin
    filt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      filt_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  // Filter stage register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) filt_q <= '0;
    else         filt_q <= filt_d;
  end

  assign cnt_src = filt_q;
`else
  assign cnt_src = data_q;
`endif

  // Per-chunk ones count; entries beyond NCHUNK stay zero to fill the tree.
  always_comb begin
    for (int c = 0; c < NPAD; c++) begin
      chunk_d[c] = '0;
    end
    for (int c = 0; c < NCHUNK; c++) begin
      for (int b = 0; b < 6; b++) begin
        chunk_d[c] = chunk_d[c] + {2'b00, cnt_src[6*c+b]};
      end
    end
  end

  // Level 0 holds chunk counts; each further level halves the node count and
  // grows by one bit until the full count width is reached.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int W = ((3 + l) < OUT_W) ? (3 + l) : OUT_W;
    localparam int N = NPAD >> l;
    logic [W-1:0] sum_q [N];

    if (l == 0) begin : g_leaf
      // Stage 1: register the chunk counts.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          for (int n = 0; n < N; n++) sum_q[n] <= '0;
        end else begin
          for (int n = 0; n < N; n++) sum_q[n] <= chunk_d[n];
        end
      end
    end else begin : g_node
      // Tree level: add adjacent pairs from the level below.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          for (int n = 0; n < N; n++) sum_q[n] <= '0;
        end else begin
          for (int n = 0; n < N; n++) begin
            sum_q[n] <= W'(g_lvl[l-1].sum_q[2*n]) + W'(g_lvl[l-1].sum_q[2*n+1]);
          end
        end
      end
    end
  end

  assign cnt_d = OUT_W'(g_lvl[LEVELS-1].sum_q[0]) + OUT_W'(g_lvl[LEVELS-1].sum_q[1]);

  // Final level: load count and flags together only for valid samples, so
  // the outputs hold their last result across bubbles.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
      full_q <= 1'b0;
    end else if (vld_q[LAT-2]) begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
      full_q <= (cnt_d == OUT_W'(WIDTH));
    end
  end

  assign oValid = vld_q[LAT-1];
  assign oCount = cnt_q;
  assign oZero  = zero_q;
  assign oFull  = full_q;

endmodule

// File: tb/tb_tdc_popcount_pipe.sv
`timescale 1ns/1ps
module tb_tdc_popcount_pipe;

  localparam int WIDTH = 192;
  localparam int OUT_W = $clog2(WIDTH + 1);
`ifdef TDC_POPCOUNT_BUBBLE_FILTER_EN
  localparam int LAT = 3 + $clog2(WIDTH / 6);
`else
  localparam int LAT = 2 + $clog2(WIDTH / 6);
`endif

  logic             iClk;
  logic             iRst_n;
  logic             iValid;
  logic [WIDTH-1:0] iData;
  logic             oValid;
  logic [OUT_W-1:0] oCount;
  logic             oZero;
  logic             oFull;

  typedef struct {
    int cnt;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_cnt = 0;
  int   last_zero = 0;
  int   last_full = 0;

  tdc_popcount_pipe #(.WIDTH(WIDTH)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (iValid),
    .iData  (iData),
    .oValid (oValid),
    .oCount (oCount),
    .oZero  (oZero),
    .oFull  (oFull)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] therm(input int n);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // What the counter is expected to see after the optional filter.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d);
`ifdef TDC_POPCOUNT_BUBBLE_FILTER_EN
    logic [WIDTH-1:0] f;
    int lo, hi, s;
    for (int i = 0; i < WIDTH; i++) begin
      lo = (i == 0) ? 1 : int'(d[i-1]);
      hi = (i == WIDTH-1) ? 0 : int'(d[i+1]);
      s  = lo + int'(d[i]) + hi;
      f[i] = (s >= 2);
    end
    return f;
`else
    return d;
`endif
  endfunction

  task automatic send(input logic [WIDTH-1:0] d, input int n);
    exp_t e;
    @(posedge iClk);
    #1;
    iValid = 1'b1;
    iData  = d;
    e.cnt = n;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      iData  = '1;
    end
  endtask

  // Output monitor: scoreboard compare on oValid, hold check otherwise.
  always @(negedge iClk) begin
    if (!iRst_n) begin
      chk("rst_valid", oValid, 0);
      chk("rst_count", oCount, 0);
      chk("rst_zero", oZero, 0);
      chk("rst_full", oFull, 0);
      last_cnt  = 0;
      last_zero = 0;
      last_full = 0;
    end else if (oValid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", oValid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("count", oCount, mon_e.cnt);
        chk("zero", oZero, (mon_e.cnt == 0));
        chk("full", oFull, (mon_e.cnt == WIDTH));
        chk("latency", cyc, mon_e.due);
        last_cnt  = mon_e.cnt;
        last_zero = (mon_e.cnt == 0) ? 1 : 0;
        last_full = (mon_e.cnt == WIDTH) ? 1 : 0;
      end
    end else begin
      chk("hold_count", oCount, last_cnt);
      chk("hold_zero", oZero, last_zero);
      chk("hold_full", oFull, last_full);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_valid", oValid, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] bub;

    iRst_n = 1'b1;
    iValid = 1'b0;
    iData  = '0;
    #1 iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b1;
    idle(2);

    send('0, 0);
    send('1, WIDTH);
    idle(3);

    send(therm(1), 1);
    send(therm(6), 6);
    send(therm(7), 7);
    send(therm(100), 100);
    send(therm(191), 191);
    idle(2);

    bub = '0;
    bub[7:0] = 8'b1101_0000;
    send(bub, 3);
    idle(2);

    send(therm(50), 50);
    idle(1);
    send(therm(20), 20);
    idle(3);

    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < WIDTH; w += 32) rd[w +: 32] = $urandom();
      send(rd, $countones(ref_model(rd)));
    end
    idle(LAT + 3);
    chk("drain_main", sb.size(), 0);

    send(therm(10), 10);
    send(therm(11), 11);
    send(therm(12), 12);
    @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    iValid = 1'b0;
    sb.delete();
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    iValid = 1'b1;
    iData  = therm(42);
    mon_e.cnt = 42;
    mon_e.due = cyc + LAT;
    sb.push_back(mon_e);
    idle(LAT + 3);
    chk("drain_after_reset", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
